// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated local RAM responder for the control unit's MAR/MDR handshake
// Accepts one request in IDLE, counts wait states, then accesses the RAM and pulses ready.
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_err
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]        WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_op_write;
    logic [IDX_W-1:0]  r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_data_out;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_one_req;
    logic w_addr_ok;
    logic w_accept;
    logic w_illegal;
    logic w_ready_d;
    logic w_busy_d;
    logic w_err_d;
    logic w_do_access;

    assign w_one_req = i_read ^ i_write;
    assign w_addr_ok = ({1'b0, i_address} < DEPTH_L);
    assign w_accept  = w_one_req & w_addr_ok;
    assign w_illegal = (i_read & i_write) | (w_one_req & ~w_addr_ok);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_WAIT;
            S_WAIT:    if (r_cnt == 4'd0) w_next = S_RESPOND;
            S_RESPOND: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs are registered: these are the values they take after the coming edge.
    always_comb begin
        w_ready_d   = 1'b0;
        w_busy_d    = 1'b0;
        w_err_d     = 1'b0;
        w_do_access = 1'b0;
        w_ready_d   = (w_next == S_RESPOND);
        w_busy_d    = (w_next != S_IDLE);
        w_err_d     = (r_state == S_IDLE) & w_illegal;
        w_do_access = (r_state == S_WAIT) & (w_next == S_RESPOND);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_data_out <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= w_ready_d;
            r_busy  <= w_busy_d;
            r_err   <= w_err_d;
            if ((r_state == S_IDLE) && w_accept) begin
                r_op_write <= i_write;
                r_addr     <= i_address[IDX_W-1:0];
                r_data     <= i_data_in;
                r_cnt      <= WAIT_L;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_do_access && !r_op_write) begin
                r_data_out <= r_mem[r_addr];
            end
        end
    end

    // RAM has no reset so its contents survive a reset; a reset edge also blocks a pending write.
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_do_access && r_op_write) begin
            r_mem[r_addr] <= r_data;
        end
    end

    assign o_data_out = r_data_out;
    assign o_ready    = r_ready;
    assign o_busy     = r_busy;
    assign o_err      = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - bench for mem_responder: directed table, hand sequences, random vs model
// Unit 0 is DEPTH=256/WAIT=2, unit 1 is DEPTH=512/WAIT=0.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_rd    [2];
    logic        s_wr    [2];
    logic [8:0]  s_addr  [2];
    logic [31:0] s_din   [2];
    logic [31:0] s_dout  [2];
    logic        s_ready [2];
    logic        s_busy  [2];
    logic        s_err   [2];

    int n_checks = 0;
    int n_pass   = 0;

    int wc    [2] = '{2, 0};
    int depth [2] = '{256, 512};

    logic [31:0] m_mem   [2][512];
    bit          m_valid [2][512];
    logic [31:0] m_dout  [2];
    bit          m_dknown[2];

    typedef struct {
        int          ready_j;
        int          ready_n;
        int          err_n;
        int          busy_n;
        logic [31:0] dout_at_ready;
        logic [31:0] dout_end;
    } obs_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [8:0]  addr;
        logic [31:0] data;
        int          exp_err;
        int          exp_ready;
        logic [31:0] exp_dout;
    } vec_t;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) u_a (
        .i_clock(clk), .i_reset(rst), .i_read(s_rd[0]), .i_write(s_wr[0]),
        .i_address(s_addr[0]), .i_data_in(s_din[0]), .o_data_out(s_dout[0]),
        .o_ready(s_ready[0]), .o_busy(s_busy[0]), .o_err(s_err[0])
    );

    mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(0)) u_b (
        .i_clock(clk), .i_reset(rst), .i_read(s_rd[1]), .i_write(s_wr[1]),
        .i_address(s_addr[1]), .i_data_in(s_din[1]), .o_data_out(s_dout[1]),
        .o_ready(s_ready[1]), .o_busy(s_busy[1]), .o_err(s_err[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic run_txn(input int u, input bit rd, input bit wr, input logic [8:0] addr,
                           input logic [31:0] data, output obs_t o);
        o = '{0, 0, 0, 0, 32'h0, 32'h0};
        @(negedge clk);
        s_rd[u] = rd; s_wr[u] = wr; s_addr[u] = addr; s_din[u] = data;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 1) begin s_rd[u] = 1'b0; s_wr[u] = 1'b0; end
            if (s_ready[u]) begin
                o.ready_n++;
                if (o.ready_j == 0) begin o.ready_j = j; o.dout_at_ready = s_dout[u]; end
            end
            if (s_err[u])  o.err_n++;
            if (s_busy[u]) o.busy_n++;
        end
        o.dout_end = s_dout[u];
    endtask

    // Transaction-level expectations: legal requests complete W+2 negedges after being driven.
    task automatic judge(input int u, input string name, input bit rd, input bit wr,
                         input logic [8:0] addr, input logic [31:0] data, input obs_t o);
        bit legal;
        legal = (rd != wr) && (int'(addr) < depth[u]);
        check({name, " ready_at"}, o.ready_j, legal ? wc[u] + 2 : 0);
        check({name, " ready_n"},  o.ready_n, legal ? 1 : 0);
        check({name, " err_n"},    o.err_n,   legal ? 0 : 1);
        check({name, " busy_n"},   o.busy_n,  legal ? wc[u] + 2 : 0);
        if (legal && rd) begin
            if (m_valid[u][addr]) begin
                check({name, " rdata"}, o.dout_at_ready, m_mem[u][addr]);
                m_dout[u] = m_mem[u][addr];
                m_dknown[u] = 1'b1;
            end else begin
                m_dknown[u] = 1'b0;
            end
        end
        if (legal && wr) begin
            m_mem[u][addr] = data;
            m_valid[u][addr] = 1'b1;
        end
        if (m_dknown[u]) check({name, " dout_hold"}, o.dout_end, m_dout[u]);
    endtask

    initial begin
        vec_t vt[$];
        obs_t o;
        int   rdy_at[$];
        int   rdy_bad;
        int   r;
        bit   rd, wr;
        logic [8:0]  a;
        logic [31:0] d;

        for (int u = 0; u < 2; u++) begin
            s_rd[u] = 1'b0; s_wr[u] = 1'b0; s_addr[u] = '0; s_din[u] = '0;
            m_dout[u] = 32'h0; m_dknown[u] = 1'b1;
            for (int i = 0; i < 512; i++) m_valid[u][i] = 1'b0;
        end

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset ready", s_ready[u], 0);
            check("reset busy",  s_busy[u],  0);
            check("reset err",   s_err[u],   0);
            check("reset dout",  s_dout[u],  0);
        end
        rst = 1'b0;

        vt.push_back('{1'b0, 1'b1, 9'd5,   32'hDEADBEEF, 0, 1, 32'h00000000});
        vt.push_back('{1'b1, 1'b0, 9'd5,   32'h0,        0, 1, 32'hDEADBEEF});
        vt.push_back('{1'b1, 1'b1, 9'd5,   32'h11111111, 1, 0, 32'hDEADBEEF});
        vt.push_back('{1'b1, 1'b0, 9'h1FF, 32'h0,        1, 0, 32'hDEADBEEF});
        vt.push_back('{1'b0, 1'b1, 9'h1FF, 32'h22222222, 1, 0, 32'hDEADBEEF});
        vt.push_back('{1'b0, 1'b1, 9'd7,   32'hCAFEF00D, 0, 1, 32'hDEADBEEF});
        vt.push_back('{1'b0, 1'b1, 9'd9,   32'h0BADF00D, 0, 1, 32'hDEADBEEF});
        vt.push_back('{1'b0, 1'b1, 9'd3,   32'h00000000, 0, 1, 32'hDEADBEEF});
        vt.push_back('{1'b1, 1'b0, 9'd7,   32'h0,        0, 1, 32'hCAFEF00D});
        vt.push_back('{1'b0, 1'b1, 9'd255, 32'h5A5A0001, 0, 1, 32'hCAFEF00D});
        vt.push_back('{1'b1, 1'b0, 9'd256, 32'h0,        1, 0, 32'hCAFEF00D});
        vt.push_back('{1'b1, 1'b0, 9'd255, 32'h0,        0, 1, 32'h5A5A0001});
        foreach (vt[i]) begin
            run_txn(0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data, o);
            check($sformatf("vec%0d err", i),   o.err_n,    vt[i].exp_err);
            check($sformatf("vec%0d ready", i), o.ready_n,  vt[i].exp_ready);
            check($sformatf("vec%0d dout", i),  o.dout_end, vt[i].exp_dout);
            judge(0, $sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data, o);
        end

        // Held read of addr 7; address wanders to 9 whenever it is not being sampled.
        @(negedge clk);
        s_rd[0] = 1'b1; s_addr[0] = 9'd7;
        rdy_bad = 0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (s_ready[0]) begin
                rdy_at.push_back(j);
                if (s_dout[0] !== 32'hCAFEF00D) rdy_bad++;
            end
            if (j == 14) s_rd[0] = 1'b0;
            s_addr[0] = (s_busy[0] && !s_ready[0]) ? 9'd9 : 9'd7;
        end
        check("held pulses", rdy_at.size(), 3);
        check("held data", rdy_bad, 0);
        if (rdy_at.size() == 3) begin
            check("held first", rdy_at[0], 4);
            check("held gap1", rdy_at[1] - rdy_at[0], 5);
            check("held gap2", rdy_at[2] - rdy_at[1], 5);
        end
        m_dout[0] = 32'hCAFEF00D;
        repeat (2) @(negedge clk);

        // Reset during WAIT must drop the pending write to addr 3.
        s_wr[0] = 1'b1; s_addr[0] = 9'd3; s_din[0] = 32'h12345678;
        @(negedge clk);
        s_wr[0] = 1'b0; rst = 1'b1;
        rdy_bad = 0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (s_ready[0]) rdy_bad++;
            if (j == 2) rst = 1'b0;
        end
        check("abort ready", rdy_bad, 0);
        check("abort busy", s_busy[0], 0);
        check("abort dout", s_dout[0], 0);
        m_dout[0] = 32'h0; m_dout[1] = 32'h0;
        m_dknown[0] = 1'b1; m_dknown[1] = 1'b1;
        run_txn(0, 1'b1, 1'b0, 9'd3, 32'h0, o);
        check("abort old data", o.dout_at_ready, 32'h0);
        judge(0, "abort read", 1'b1, 1'b0, 9'd3, 32'h0, o);

        run_txn(1, 1'b0, 1'b1, 9'd0, 32'hA5A5A5A5, o);
        check("w0 latency", o.ready_j, 2);
        judge(1, "w0 write", 1'b0, 1'b1, 9'd0, 32'hA5A5A5A5, o);
        run_txn(1, 1'b1, 1'b0, 9'd0, 32'h0, o);
        check("w0 rdata", o.dout_at_ready, 32'hA5A5A5A5);
        judge(1, "w0 read", 1'b1, 1'b0, 9'd0, 32'h0, o);

        for (int n = 0; n < 60; n++) begin
            int u;
            u = (n < 40) ? 0 : 1;
            r = $urandom_range(0, 9);
            rd = (r <= 4);
            wr = (r == 0) || (r >= 5);
            a = ($urandom_range(0, 7) == 0) ? 9'(256 + $urandom_range(0, 255)) : 9'($urandom_range(0, 15));
            d = $urandom;
            run_txn(u, rd, wr, a, d, o);
            judge(u, $sformatf("rand%0d", n), rd, wr, a, d, o);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
